// File: rtl/tmds_rx_decode_pkg.sv
// tmds_rx_decode_pkg
// Shared definitions for the TMDS receive decoder: the four control-token
// symbols, the per-channel aligner state type, the width of the measured
// timing values and small helper functions that classify and decode a
// 10-bit aligned TMDS symbol.
package tmds_rx_decode_pkg;

  localparam int TIMING_W = 12;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  function automatic logic is_ctrl(input logic [9:0] s);
    return (s == CTRL_00) || (s == CTRL_01) || (s == CTRL_10) || (s == CTRL_11);
  endfunction

  // Returns {c1,c0}; only meaningful when is_ctrl(s) is true.
  function automatic logic [1:0] ctrl_bits(input logic [9:0] s);
    logic [1:0] c;
    case (s)
      CTRL_01: c = 2'b01;
      CTRL_10: c = 2'b10;
      CTRL_11: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  function automatic logic [7:0] decode_data(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] q;
    d = s[9] ? ~s[7:0] : s[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_rx_decode_chan.sv
// tmds_chan_decoder
// One TMDS channel: builds a 20-bit window from the current and previous
// parallel words, picks a 10-bit symbol at bit offset off, hunts for the
// offset that yields a steady run of control tokens, and decodes the
// aligned symbol into control bits or 8-bit data.
// Ports:
//   clk, rst   pixel clock, synchronous active-high reset
//   sym        raw 10-bit parallel word, bit 0 first on the wire
//   locked     aligner is in LOCKED
//   tok        decoded symbol is a control token
//   ctrl       last control value seen {c1,c0}, held through data periods
//   data       decoded 8-bit data
module tmds_chan_decoder
  import tmds_rx_decode_pkg::*;
#(
  parameter int TIMEOUT  = 4096,
  parameter int LOCK_RUN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sym,
  output logic       locked,
  output logic       tok,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(LOCK_RUN + 1);

  align_state_t  state, state_n;
  logic [3:0]    off, off_n, off_adv;
  logic [TW-1:0] idle_cnt, idle_n;
  logic [RW-1:0] run_cnt, run_n;
  logic [9:0]    prev, aligned, slice;
  logic [19:0]   win;
  logic          slice_tok;

  // The newer word sits above the older one, so offset k starts k bits
  // into the previous word on the wire.
  assign win       = {sym, prev};
  assign slice     = 10'(win >> off);
  assign slice_tok = is_ctrl(slice);
  assign off_adv   = (off == 4'd9) ? 4'd0 : off + 4'd1;
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      off      <= '0;
      idle_cnt <= '0;
      run_cnt  <= '0;
    end else begin
      state    <= state_n;
      off      <= off_n;
      idle_cnt <= idle_n;
      run_cnt  <= run_n;
    end
  end

  // Token detection uses the unregistered slice so a new offset is judged
  // on the very next word.
  always_comb begin
    state_n = state;
    off_n   = off;
    idle_n  = slice_tok ? '0 : idle_cnt + 1'b1;
    run_n   = run_cnt;
    case (state)
      SEARCH: begin
        if (slice_tok) begin
          if (run_cnt == RW'(LOCK_RUN - 1)) begin
            state_n = LOCKED;
            run_n   = '0;
          end else begin
            run_n = run_cnt + 1'b1;
          end
        end else begin
          run_n = '0;
          if (idle_cnt == TW'(TIMEOUT - 1)) begin
            off_n  = off_adv;
            idle_n = '0;
          end
        end
      end
      LOCKED: begin
        if (!slice_tok && idle_cnt == TW'(TIMEOUT - 1)) begin
          state_n = SEARCH;
          off_n   = off_adv;
          idle_n  = '0;
          run_n   = '0;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  // prev -> aligned -> decode: three registers from input to outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= '0;
      aligned <= '0;
      tok     <= 1'b0;
      ctrl    <= '0;
      data    <= '0;
    end else begin
      prev    <= sym;
      aligned <= slice;
      tok     <= is_ctrl(aligned);
      data    <= decode_data(aligned);
      if (is_ctrl(aligned)) ctrl <= ctrl_bits(aligned);
    end
  end

endmodule

// File: rtl/tmds_rx_decode.sv
// tmds_rx_decode
// Three-channel TMDS receiver: per-channel word alignment and decode, then
// sync/vde generation from the blue channel and measurement of the video
// timing while all channels are locked.
// Ports:
//   pix_clk, sys_rst                  clock, synchronous active-high reset
//   tmds_0/1/2                        blue/green/red raw 10-bit words
//   red_data, green_data, blue_data   decoded pixels, zero outside vde
//   hsync, vsync, vde                 decoded syncs and data enable
//   locked                            all three channels locked
//   hactive, htotal, vactive, vtotal  measured timing, updated per frame
module tmds_rx_decode
  import tmds_rx_decode_pkg::*;
#(
  parameter int TIMEOUT  = 4096,
  parameter int LOCK_RUN = 8
) (
  input  logic                pix_clk,
  input  logic                sys_rst,
  input  logic [9:0]          tmds_0,
  input  logic [9:0]          tmds_1,
  input  logic [9:0]          tmds_2,
  output logic [7:0]          red_data,
  output logic [7:0]          green_data,
  output logic [7:0]          blue_data,
  output logic                hsync,
  output logic                vsync,
  output logic                vde,
  output logic                locked,
  output logic [TIMING_W-1:0] hactive,
  output logic [TIMING_W-1:0] htotal,
  output logic [TIMING_W-1:0] vactive,
  output logic [TIMING_W-1:0] vtotal
);

  logic       b_lock, g_lock, r_lock, b_tok, g_tok, r_tok;
  logic [1:0] b_ctrl, g_ctrl, r_ctrl;
  logic [7:0] b_data, g_data, r_data;
  logic       unused_ctrl;

  tmds_chan_decoder #(.TIMEOUT(TIMEOUT), .LOCK_RUN(LOCK_RUN)) u_blue (
    .clk(pix_clk), .rst(sys_rst), .sym(tmds_0),
    .locked(b_lock), .tok(b_tok), .ctrl(b_ctrl), .data(b_data));
  tmds_chan_decoder #(.TIMEOUT(TIMEOUT), .LOCK_RUN(LOCK_RUN)) u_green (
    .clk(pix_clk), .rst(sys_rst), .sym(tmds_1),
    .locked(g_lock), .tok(g_tok), .ctrl(g_ctrl), .data(g_data));
  tmds_chan_decoder #(.TIMEOUT(TIMEOUT), .LOCK_RUN(LOCK_RUN)) u_red (
    .clk(pix_clk), .rst(sys_rst), .sym(tmds_2),
    .locked(r_lock), .tok(r_tok), .ctrl(r_ctrl), .data(r_data));

  // Only blue carries syncs and defines vde; the other channels' control
  // information is not needed because channels arrive word-coincident.
  assign unused_ctrl = ^{g_tok, g_ctrl, r_tok, r_ctrl};

  assign locked     = b_lock & g_lock & r_lock;
  assign vde        = locked & ~b_tok;
  assign hsync      = locked & b_ctrl[0];
  assign vsync      = locked & b_ctrl[1];
  assign blue_data  = vde ? b_data : '0;
  assign green_data = vde ? g_data : '0;
  assign red_data   = vde ? r_data : '0;

  function automatic logic [TIMING_W-1:0] sat_inc(input logic [TIMING_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic                hs_d, vs_d, vde_d, armed, line_vde;
  logic                hs_rise, vs_rise, act_inc;
  logic [TIMING_W-1:0] h_cnt, h_last, run_cnt, run_last, line_cnt, act_cnt, act_next;

  assign hs_rise  = hsync & ~hs_d;
  assign vs_rise  = vsync & ~vs_d;
  assign act_inc  = hs_rise & line_vde;
  assign act_next = act_inc ? sat_inc(act_cnt) : act_cnt;

  // A line counts as active when vde was seen since the previous hsync
  // rise. The first vsync rise after (re)lock only arms the counters; the
  // outputs keep their last frame's values across lock loss.
  always_ff @(posedge pix_clk) begin
    if (sys_rst) begin
      {hs_d, vs_d, vde_d, armed, line_vde} <= '0;
      {h_cnt, h_last, run_cnt, run_last, line_cnt, act_cnt} <= '0;
      {hactive, htotal, vactive, vtotal} <= '0;
    end else begin
      hs_d  <= hsync;
      vs_d  <= vsync;
      vde_d <= vde;
      if (!locked) begin
        armed    <= 1'b0;
        line_vde <= 1'b0;
        {h_cnt, h_last, run_cnt, run_last, line_cnt, act_cnt} <= '0;
      end else begin
        if (hs_rise) begin
          h_last <= h_cnt;
          h_cnt  <= TIMING_W'(1);
        end else begin
          h_cnt <= sat_inc(h_cnt);
        end
        if (vde)        run_cnt  <= vde_d ? sat_inc(run_cnt) : TIMING_W'(1);
        else if (vde_d) run_last <= run_cnt;
        if (hs_rise)    line_vde <= vde;
        else if (vde)   line_vde <= 1'b1;
        if (vs_rise) begin
          armed    <= 1'b1;
          line_cnt <= hs_rise ? TIMING_W'(1) : '0;
          act_cnt  <= '0;
          if (armed) begin
            htotal  <= h_last;
            hactive <= run_last;
            vtotal  <= line_cnt;
            vactive <= act_next;
          end
        end else begin
          line_cnt <= hs_rise ? sat_inc(line_cnt) : line_cnt;
          act_cnt  <= act_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmds_rx_decode.sv
// tb_tmds_rx_decode
// Scoreboard bench for tmds_rx_decode: directed symbol streams (aligned and
// bit-rotated), hand-decoded pixel expectations queued as data is sent and
// popped by a monitor whenever vde is high, plus directed checks of lock,
// latency, timing measurement, lock loss and reset.
module tb_tmds_rx_decode;
  import tmds_rx_decode_pkg::*;

  localparam int TO = 64;
  localparam int LR = 8;

  logic                pix_clk = 1'b0;
  logic                sys_rst = 1'b1;
  logic [9:0]          tmds_0 = '0, tmds_1 = '0, tmds_2 = '0;
  logic [7:0]          red_data, green_data, blue_data;
  logic                hsync, vsync, vde, locked;
  logic [TIMING_W-1:0] hactive, htotal, vactive, vtotal;

  typedef struct packed { logic [7:0] b, g, r; } pix_t;
  pix_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   rot = 0;
  logic [9:0] last_0 = '0, last_1 = '0, last_2 = '0;

  // Raw symbols {blue, green, red} and their hand-decoded bytes.
  logic [9:0] pat_sym [2][3] = '{'{10'h100, 10'h200, 10'h100}, '{10'h1AA, 10'h2F0, 10'h10F}};
  logic [7:0] pat_exp [2][3] = '{'{8'h00, 8'hFF, 8'h00}, '{8'hFE, 8'hEF, 8'h11}};

  always #5 pix_clk = ~pix_clk;

  tmds_rx_decode #(.TIMEOUT(TO), .LOCK_RUN(LR)) u_dut (
    .pix_clk(pix_clk), .sys_rst(sys_rst),
    .tmds_0(tmds_0), .tmds_1(tmds_1), .tmds_2(tmds_2),
    .red_data(red_data), .green_data(green_data), .blue_data(blue_data),
    .hsync(hsync), .vsync(vsync), .vde(vde), .locked(locked),
    .hactive(hactive), .htotal(htotal), .vactive(vactive), .vtotal(vtotal));

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one symbol per channel, rotated by rot bits on the wire, and
  // advances one clock.
  task automatic applyStimulus(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
    logic [19:0] t;
    t = {b, last_0}; tmds_0 = 10'(t >> (10 - rot));
    t = {g, last_1}; tmds_1 = 10'(t >> (10 - rot));
    t = {r, last_2}; tmds_2 = 10'(t >> (10 - rot));
    last_0 = b; last_1 = g; last_2 = r;
    @(posedge pix_clk); #1;
  endtask

  task automatic sendData(input int p, input bit push);
    pix_t e;
    e.b = pat_exp[p][0]; e.g = pat_exp[p][1]; e.r = pat_exp[p][2];
    if (push) exp_q.push_back(e);
    applyStimulus(pat_sym[p][0], pat_sym[p][1], pat_sym[p][2]);
  endtask

  task automatic sendTokens(input int n);
    for (int i = 0; i < n; i++) applyStimulus(CTRL_00, CTRL_00, CTRL_00);
  endtask

  function automatic logic [9:0] tokFor(input logic [1:0] c);
    case (c)
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      2'b11:   return CTRL_11;
      default: return CTRL_00;
    endcase
  endfunction

  // 10 lines of 20 cycles: 12 data cycles on lines 0-5, hsync on cycles
  // 14-17, vsync on lines 7-8.
  task automatic sendFrame();
    for (int ln = 0; ln < 10; ln++) begin
      for (int cy = 0; cy < 20; cy++) begin
        if (ln < 6 && cy < 12) sendData(0, 1'b1);
        else applyStimulus(tokFor({ln == 7 || ln == 8, cy >= 14 && cy <= 17}), CTRL_00, CTRL_00);
      end
    end
  endtask

  task automatic doReset(input int r);
    sys_rst = 1'b1;
    rot = r;
    sendTokens(4);
    sys_rst = 1'b0;
  endtask

  task automatic waitLock(input int bound, input string name, output int used);
    used = bound;
    for (int i = 1; i <= bound; i++) begin
      applyStimulus(CTRL_00, CTRL_00, CTRL_00);
      if (locked) begin
        used = i;
        break;
      end
    end
    checkOutput(name, locked, 1);
  endtask

  always @(negedge pix_clk) begin
    pix_t e;
    if (!sys_rst && vde) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL pixel_unexpected: actual b/g/r %h/%h/%h, expected no pixel",
                 blue_data, green_data, red_data);
      end else begin
        e = exp_q.pop_front();
        if ({blue_data, green_data, red_data} !== e) begin
          mismatched++;
          $display("[TB] FAIL pixel: actual b/g/r %h/%h/%h, expected %h/%h/%h",
                   blue_data, green_data, red_data, e.b, e.g, e.r);
        end
      end
    end
  end

  initial begin
    int used;

    $display("[TB] reset");
    doReset(0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_vde", vde, 0);
    checkOutput("rst_syncs", {hsync, vsync}, 0);
    checkOutput("rst_colors", {red_data, green_data, blue_data}, 0);
    checkOutput("rst_htotal", htotal, 0);
    checkOutput("rst_vtotal", vtotal, 0);

    $display("[TB] aligned token stream");
    waitLock(LR + 3, "lock_aligned", used);
    sendTokens(100 - used);
    checkOutput("aligned_locked", locked, 1);
    checkOutput("aligned_hsync", hsync, 0);
    checkOutput("aligned_vsync", vsync, 0);
    checkOutput("aligned_vde", vde, 0);

    $display("[TB] data decode and latency");
    sendData(0, 1'b1);
    applyStimulus(CTRL_00, CTRL_00, CTRL_00);
    checkOutput("latency_not_early", vde, 0);
    applyStimulus(CTRL_00, CTRL_00, CTRL_00);
    checkOutput("latency_three", vde, 1);
    for (int i = 0; i < 4; i++) sendData(1, 1'b1);
    sendTokens(6);
    checkOutput("queue_after_decode", exp_q.size(), 0);

    $display("[TB] timing measurement");
    sendFrame();
    checkOutput("first_vs_htotal", htotal, 0);
    checkOutput("first_vs_vtotal", vtotal, 0);
    sendFrame();
    sendFrame();
    sendTokens(6);
    checkOutput("htotal", htotal, 20);
    checkOutput("hactive", hactive, 12);
    checkOutput("vtotal", vtotal, 10);
    checkOutput("vactive", vactive, 6);
    checkOutput("queue_after_frames", exp_q.size(), 0);

    $display("[TB] lock loss");
    for (int i = 0; i < TO + 8; i++) sendData(0, 1'b1);
    checkOutput("loss_locked", locked, 0);
    checkOutput("loss_vde", vde, 0);
    checkOutput("loss_off", u_dut.u_blue.off, 1);
    checkOutput("loss_htotal_held", htotal, 20);
    checkOutput("loss_hactive_held", hactive, 12);
    checkOutput("loss_vtotal_held", vtotal, 10);
    checkOutput("loss_vactive_held", vactive, 6);
    exp_q.delete();

    $display("[TB] misaligned stream");
    doReset(3);
    checkOutput("rst2_htotal", htotal, 0);
    checkOutput("rst2_locked", locked, 0);
    waitLock(3 * TO + LR + 3, "lock_misaligned", used);
    checkOutput("misaligned_off", u_dut.u_blue.off, 3);
    sendData(0, 1'b1);
    for (int i = 0; i < 3; i++) sendData(1, 1'b1);
    sendTokens(8);
    checkOutput("queue_after_misaligned", exp_q.size(), 0);

    $display("[TB] reset during data");
    sendData(1, 1'b0);
    sendData(1, 1'b0);
    sys_rst = 1'b1;
    sendData(1, 1'b0);
    checkOutput("midrst_locked", locked, 0);
    checkOutput("midrst_vde", vde, 0);
    checkOutput("midrst_off", u_dut.u_blue.off, 0);
    sendTokens(2);
    sys_rst = 1'b0;
    sendTokens(4);
    checkOutput("queue_final", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
